// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: request bundle and arbiter state.
// The bundle widths here bound the DATA_W / DM_ADDRESS parameters of dmem_arbiter.
package Pipe_Buf_Reg_PKG;

    localparam int DM_DATA_W = 32;
    localparam int DM_ADDR_W = 9;

    typedef struct packed {
        logic                 rd;
        logic                 wr;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [2:0]           func3;
    } dm_req_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive denied secondary cycles; full marks a forced grant.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic full
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (!req || gnt) begin
            count_next = '0;
        end else if (count_reg != MAX_CNT) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign full = (count_reg == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (priority) and a secondary master.
// Optional DMEM_ARB_LOCK_EN adds s_lock and a LOCKED state that freezes the pipeline for bursts.
module dmem_arbiter
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int DM_ADDRESS = DM_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_rd,
    input  logic                  p_wr,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_func3,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_stall,
    input  logic                  s_req,
    input  logic                  s_we,
    input  logic [DM_ADDRESS-1:0] s_addr,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [2:0]            s_func3,
    output logic                  s_gnt,
    output logic                  s_rvalid,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_func3,
    input  logic [DATA_W-1:0]     m_rdata
`ifdef DMEM_ARB_LOCK_EN
    ,
    input  logic                  s_lock
`endif
);

    dm_req_t    p_bus, s_bus, m_bus;
    arb_state_e state_reg, state_next;
    logic       p_act;
    logic       starve_full;
    logic       s_rvalid_reg;
    logic [DATA_W-1:0] s_rdata_reg;

    assign p_act = reset & (p_rd | p_wr);

    always_comb begin
        p_bus = '{rd: p_rd, wr: p_wr, addr: p_addr, wdata: p_wdata, func3: p_func3};
        s_bus = '{rd: ~s_we, wr: s_we, addr: s_addr, wdata: s_wdata, func3: s_func3};
    end

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .req   (s_req),
        .gnt   (s_gnt),
        .full  (starve_full)
    );

    // A stalled pipeline access is dropped from the port rather than passed through.
    always_comb begin
        s_gnt   = 1'b0;
        p_stall = 1'b0;
        m_bus   = '0;
        if (reset) begin
            if (state_reg == LOCKED) begin
                s_gnt   = s_req;
                p_stall = p_act;
            end else begin
                s_gnt   = s_req & (~p_act | starve_full);
                p_stall = p_act & s_gnt;
            end
            if (s_gnt) begin
                m_bus = s_bus;
            end else if (!p_stall) begin
                m_bus = p_bus;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
`ifdef DMEM_ARB_LOCK_EN
        case (state_reg)
            ARB:     if (s_gnt && s_lock) state_next = LOCKED;
            LOCKED:  if (!s_lock || !s_req) state_next = ARB;
            default: state_next = ARB;
        endcase
`else
        state_next = ARB;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ARB;
            s_rvalid_reg <= 1'b0;
            s_rdata_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            s_rvalid_reg <= s_gnt & ~s_we;
            if (s_gnt && !s_we) begin
                s_rdata_reg <= m_rdata;
            end
        end
    end

    assign m_rd     = m_bus.rd;
    assign m_wr     = m_bus.wr;
    assign m_addr   = m_bus.addr;
    assign m_wdata  = m_bus.wdata;
    assign m_func3  = m_bus.func3;
    assign p_rdata  = m_rdata;
    assign s_rvalid = s_rvalid_reg;
    assign s_rdata  = s_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_rd, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [2:0]    p_func3;
    logic [DW-1:0] p_rdata;
    logic          p_stall;
    logic          s_req, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [2:0]    s_func3;
    logic          s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [2:0]    m_func3;
    logic [DW-1:0] m_rdata;
    logic          s_lock;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W     (DW),
        .DM_ADDRESS (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_rd     (p_rd),
        .p_wr     (p_wr),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_func3  (p_func3),
        .p_rdata  (p_rdata),
        .p_stall  (p_stall),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_func3  (s_func3),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .m_rd     (m_rd),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_func3  (m_func3),
        .m_rdata  (m_rdata)
`ifdef DMEM_ARB_LOCK_EN
        ,
        .s_lock   (s_lock)
`endif
    );

    function automatic logic [31:0] seed(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Word-wide data memory with combinational read, preloaded on the first edge.
    logic [31:0] mem [0:127];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= seed(i);
            mem_init <= 1'b1;
        end else if (m_wr) begin
            mem[m_addr[8:2]] <= m_wdata;
        end
    end
    assign m_rdata = mem[m_addr[8:2]];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:127];
    int          ref_wait;
    bit          ref_rv;
    logic [31:0] ref_rd;
    bit          ref_locked;

    logic          obs_gnt, obs_stall, obs_rvalid;
    logic [DW-1:0] obs_prdata, obs_srdata;
    bit            last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0; p_func3 = 3'd2;
        s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0; s_func3 = 3'd2;
        s_lock = 0;
    endtask

    task automatic model_reset();
        ref_wait = 0; ref_rv = 0; ref_locked = 0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit pa, eg, es;
        @(negedge clk);
        pa = p_rd | p_wr;
        eg = s_req && (ref_locked || !pa || ref_wait >= SM);
        es = ref_locked ? pa : (pa && eg);
        obs_gnt = s_gnt; obs_stall = p_stall; obs_rvalid = s_rvalid;
        obs_prdata = p_rdata; obs_srdata = s_rdata;
        chk("s_gnt", 32'(s_gnt), 32'(eg));
        chk("p_stall", 32'(p_stall), 32'(es));
        chk("m_rd", 32'(m_rd), eg ? 32'(!s_we) : 32'(!es && p_rd));
        chk("m_wr", 32'(m_wr), eg ? 32'(s_we) : 32'(!es && p_wr));
        if (eg) begin
            chk("m_addr_s", 32'(m_addr), 32'(s_addr));
            chk("m_func3_s", 32'(m_func3), 32'(s_func3));
            if (s_we) chk("m_wdata_s", m_wdata, s_wdata);
        end else if (!es && pa) begin
            chk("m_addr_p", 32'(m_addr), 32'(p_addr));
            chk("m_func3_p", 32'(m_func3), 32'(p_func3));
            if (p_rd) chk("p_rdata", p_rdata, ref_mem[p_addr[8:2]]);
            if (p_wr) chk("m_wdata_p", m_wdata, p_wdata);
        end
        chk("s_rvalid", 32'(s_rvalid), 32'(ref_rv));
        if (ref_rv) chk("s_rdata", s_rdata, ref_rd);
        last_gnt = eg;
        @(posedge clk);
        ref_rv = eg && !s_we;
        if (ref_rv) ref_rd = ref_mem[s_addr[8:2]];
        if (eg && s_we) ref_mem[s_addr[8:2]] = s_wdata;
        else if (!eg && !es && p_wr) ref_mem[p_addr[8:2]] = p_wdata;
        ref_wait = (s_req && !eg) ? ((ref_wait < SM) ? ref_wait + 1 : SM) : 0;
        if (!ref_locked && eg && s_lock) ref_locked = 1;
        else if (ref_locked && (!s_lock || !s_req)) ref_locked = 0;
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return {7'($urandom_range(0, 127)), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = seed(i);
        model_reset();
        clr();

        // Reset holds every grant/enable low even with both sides requesting.
        reset = 0; s_req = 1; p_rd = 1; p_addr = 9'h040;
        #2;
        chk("rst_s_gnt", 32'(s_gnt), 0);
        chk("rst_p_stall", 32'(p_stall), 0);
        chk("rst_m_rd", 32'(m_rd), 0);
        chk("rst_s_rvalid", 32'(s_rvalid), 0);
        chk("rst_s_rdata", s_rdata, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(s_gnt), 0);
        reset = 1;
        clr();

        // Idle pipeline: secondary read granted at once, data one cycle later.
        s_req = 1; s_we = 0; s_addr = 9'h010;
        step();
        chk("idle_gnt", 32'(obs_gnt), 1);
        clr();
        step();
        chk("idle_rvalid", 32'(obs_rvalid), 1);
        chk("idle_rdata", obs_srdata, 32'hDEADBEEF);
        step();
        chk("idle_rvalid_pulse", 32'(obs_rvalid), 0);

        // Continuous pipeline reads: forced grant on cycle STARVE_MAX+1.
        p_rd = 1; p_addr = 9'h040; s_req = 1; s_we = 0; s_addr = 9'h010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("starve_gnt_c%0d", i + 1), 32'(obs_gnt), (i == SM) ? 1 : 0);
            chk($sformatf("starve_stall_c%0d", i + 1), 32'(obs_stall), (i == SM) ? 1 : 0);
        end
        clr();
        step();

        // Secondary write then pipeline read of the same word.
        s_req = 1; s_we = 1; s_addr = 9'h020; s_wdata = 32'h12345678;
        step();
        chk("wr_gnt", 32'(obs_gnt), 1);
        clr();
        p_rd = 1; p_addr = 9'h020;
        step();
        chk("wr_rd_order", obs_prdata, 32'h12345678);
        chk("wr_rd_stall", 32'(obs_stall), 0);

        // Withdrawn request clears the wait count: a fresh wait takes the full STARVE_MAX again.
        p_rd = 1; p_addr = 9'h044; s_req = 1; s_we = 0; s_addr = 9'h018;
        step(); chk("wd_stall_1", 32'(obs_stall), 0);
        step(); chk("wd_stall_2", 32'(obs_stall), 0);
        s_req = 0;
        step(); chk("wd_gnt_drop", 32'(obs_gnt), 0);
        s_req = 1;
        for (int i = 0; i < SM + 1; i++) begin
            step();
            chk($sformatf("wd_regnt_c%0d", i + 1), 32'(obs_gnt), (i == SM) ? 1 : 0);
        end
        clr();
        step();

        // Reset mid-operation discards a pending read return.
        s_req = 1; s_we = 0; s_addr = 9'h010;
        step();
        reset = 0;
        #1;
        chk("midrst_rvalid", 32'(s_rvalid), 0);
        chk("midrst_rdata", s_rdata, 0);
        chk("midrst_gnt", 32'(s_gnt), 0);
        model_reset();
        clr();
        @(posedge clk);
        #1;
        reset = 1;

`ifdef DMEM_ARB_LOCK_EN
        // Locked burst: pipeline frozen for every locked write, served once the lock ends.
        s_req = 1; s_we = 1; s_lock = 1; s_addr = 9'h030; s_wdata = $urandom;
        step();
        chk("lock_first_gnt", 32'(obs_gnt), 1);
        for (int k = 0; k < 3; k++) begin
            p_wr = 1; p_addr = 9'h060; p_wdata = $urandom;
            s_addr = 9'(9'h034 + 4 * k); s_wdata = $urandom;
            step();
            chk($sformatf("lock_stall_%0d", k), 32'(obs_stall), 1);
            chk($sformatf("lock_gnt_%0d", k), 32'(obs_gnt), 1);
        end
        s_lock = 0; s_req = 0;
        step();
        step();
        chk("unlock_served", 32'(obs_stall), 0);
        clr();
        for (int k = 0; k < 4; k++) begin
            p_rd = 1; p_addr = 9'(9'h030 + 4 * k);
            step();
        end
        clr();
`endif

        // Randomized traffic; an ungranted secondary request is usually held.
        for (int n = 0; n < 400; n++) begin
            int pk;
            pk = $urandom_range(0, 3);
            p_rd = (pk == 1); p_wr = (pk == 2);
            p_addr = rand_addr(); p_wdata = $urandom; p_func3 = 3'($urandom_range(0, 5));
            if (!(s_req && !last_gnt && $urandom_range(0, 9) != 0)) begin
                s_req = ($urandom_range(0, 2) != 0);
                s_we = $urandom_range(0, 1) == 1;
                s_addr = rand_addr(); s_wdata = $urandom; s_func3 = 3'($urandom_range(0, 5));
            end
`ifdef DMEM_ARB_LOCK_EN
            s_lock = ($urandom_range(0, 7) == 0);
`endif
            step();
        end
        clr();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
